id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Decode/issue stage between instruction fetch and execute (RV32I integer core).
//  - Drives register-file read addresses and captures the read operands into an ID/EX pipeline register.
//  - Generates the immediate.
//  - Tracks in-flight register writes in a scoreboard and stalls on RAW and WAW hazards.
//  - Bypasses same-cycle write-back data, because the register file updates only on the clock edge.
// PARAMETERS
//  XLEN       32  datapath width
//  NUM_REGS   32  architectural registers; index width = $clog2(NUM_REGS)
//  BYPASS_EN  1   1: wb_data bypassed to operands in the write-back cycle; 0: stall one extra cycle instead
// PORTS
//  clk          in   1     clock, rising edge
//  reset        in   1     asynchronous, active-high
//  if_valid     in   1     fetch presents an instruction
//  if_ready     out  1     stage accepts if_* this cycle
//  if_instr     in   32    instruction word
//  if_pc        in   XLEN  PC of if_instr
//  rf_rs1       out  5     register-file read address 1 (= if_instr[19:15])
//  rf_rs2       out  5     register-file read address 2 (= if_instr[24:20])
//  rf_rdata1    in   XLEN  combinational read data 1
//  rf_rdata2    in   XLEN  combinational read data 2
//  wb_we        in   1     write-back strobe (same signal as register-file write enable)
//  wb_rd        in   5     write-back destination
//  wb_data      in   XLEN  write-back data
//  flush        in   1     EX redirect: discard the ID/EX contents and the incoming instruction
//  ex_valid     out  1     ID/EX register holds an instruction
//  ex_ready     in   1     EX consumes the ID/EX contents this cycle
//  ex_pc, ex_instr  out  XLEN/32  captured PC and instruction word
//  ex_op1, ex_op2   out  XLEN     resolved operands
//  ex_imm       out  XLEN  sign-extended immediate
//  ex_rd        out  5     destination register
//  ex_reg_write out  1     instruction writes rd (0 when rd = x0)
//  ex_illegal   out  1     opcode not in supported set
// BEHAVIOUR
//  Reset: every ex_* output = 0 and scoreboard pend[] = 0. if_ready is combinational.
//  Decode, by opcode:
//    - LUI/AUIPC (U-imm), JAL (J-imm), JALR/LOAD/OP-IMM (I-imm), STORE (S-imm), BRANCH (B-imm), OP (imm = 0).
//    - Any other opcode: ex_illegal = 1, no sources, no write.
//    - use_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
//    - use_rs2: BRANCH, STORE, OP.
//    - reg_write: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and only when rd != 0.
//  Operand resolution:
//    - Source x0 -> 0.
//    - Else if BYPASS_EN && wb_we && wb_rd == rs -> wb_data.
//    - Else rf_rdata.
//  busy(r) = r != 0 && ((pend[r] && !(BYPASS_EN && wb_we && wb_rd == r)) || (ex_valid && ex_reg_write && ex_rd == r)).
//  hazard = if_valid && ((use_rs1 && busy(rs1)) || (use_rs2 && busy(rs2)) || (reg_write && busy(rd))).
//  if_ready = !flush && !hazard && (!ex_valid || ex_ready).
//  Accept (if_valid && if_ready): ID/EX loads the decoded fields and ex_valid = 1 on the next edge. Latency is 1 cycle.
//  Handoff (ex_valid && ex_ready && !flush) with no accept: ex_valid = 0. ex_* data holds its last value.
//  Hold (ex_valid && !ex_ready): all ex_* are stable and no new accept occurs.
//  Scoreboard:
//    - Set pend[ex_rd] on handoff when ex_reg_write = 1.
//    - Clear pend[wb_rd] on wb_we (x0 is never set).
//    - Set and clear of the same index in the same cycle: set wins.
//  flush:
//    - Next cycle ex_valid = 0 and the incoming instruction is dropped.
//    - The discarded ID/EX instruction never sets pend, even if ex_ready = 1.
//    - pend[] is untouched; older in-flight writes still retire normally.
//  Conservative rule: an instruction leaving ID/EX in the current cycle still blocks dependents in that cycle.
//  Reset mid-operation: immediate return to the reset state; in-flight scoreboard state is lost.
// TESTING
//  1. Reset asserted mid-stream -> ex_valid = 0, all ex_* = 0, pend = 0 within the same cycle.
//  2. ADDI x1,x0,5 then ADD x2,x1,x1, ex_ready = 1, no wb -> ADD stalls (if_ready = 0) until wb_we,
//     wb_rd = 1, wb_data = 5; in that cycle ADD is accepted with ex_op1 = ex_op2 = 5 (BYPASS_EN = 1).
//  3. Same as 2 with BYPASS_EN = 0 -> ADD accepted one cycle after wb; operands taken from rf_rdata.
//  4. SW x3,8(x4) -> ex_imm = 8, ex_reg_write = 0, ex_rd field ignored. BEQ offset -4 -> ex_imm = 0xFFFFFFFC.
//     Opcode 0x7F -> ex_illegal = 1.
//  5. ex_ready = 0 for 3 cycles with ex_valid = 1 -> ex_* stable and if_ready = 0. Then a flush pulse ->
//     ex_valid = 0 and pend[ex_rd] not set.
//  6. Two writes to x5 back to back -> second is held (WAW) until the first write-back; x0 destinations never stall.

Source files
------------

// File: rtl/id_stage_if.sv
// Decode-stage bundle: fetch handshake, register-file read port, write-back
// snoop, flush and the ID/EX handshake with its payload.
interface id_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;

    logic [4:0]      rf_rs1;
    logic [4:0]      rf_rs2;
    logic [XLEN-1:0] rf_rdata1;
    logic [XLEN-1:0] rf_rdata2;

    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            flush;

    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic [31:0]     ex_instr;
    logic [XLEN-1:0] ex_op1;
    logic [XLEN-1:0] ex_op2;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rd;
    logic            ex_reg_write;
    logic            ex_illegal;

    // Pipeline environment (fetch, register file, write-back, execute).
    modport master (
        output if_valid, if_instr, if_pc, rf_rdata1, rf_rdata2, wb_we, wb_rd, wb_data, flush,
               ex_ready,
        input  if_ready, rf_rs1, rf_rs2, ex_valid, ex_pc, ex_instr, ex_op1, ex_op2, ex_imm, ex_rd,
               ex_reg_write, ex_illegal
    );

    // Decode stage.
    modport slave (
        input  if_valid, if_instr, if_pc, rf_rdata1, rf_rdata2, wb_we, wb_rd, wb_data, flush,
               ex_ready,
        output if_ready, rf_rs1, rf_rs2, ex_valid, ex_pc, ex_instr, ex_op1, ex_op2, ex_imm, ex_rd,
               ex_reg_write, ex_illegal
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode/issue stage: immediate generation, operand capture with write-back
// bypass, and a pending-write scoreboard that stalls on RAW and WAW hazards.
module id_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter bit          BYPASS_EN = 1'b1
) (
    input logic       clk,
    input logic       reset,
    id_stage_if.slave bus
);
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode;

    assign instr  = bus.if_instr;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign bus.rf_rs1 = rs1;
    assign bus.rf_rs2 = rs2;

    logic        use_rs1, use_rs2, writes, illegal, reg_write;
    logic [31:0] imm;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        writes  = 1'b0;
        illegal = 1'b0;
        imm     = '0;
        case (opcode)
            OpLui, OpAuipc: begin
                writes = 1'b1;
                imm    = {instr[31:12], 12'b0};
            end
            OpJal: begin
                writes = 1'b1;
                imm    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OpJalr, OpLoad, OpImm: begin
                use_rs1 = 1'b1;
                writes  = 1'b1;
                imm     = {{20{instr[31]}}, instr[31:20]};
            end
            OpStore: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OpBranch: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OpReg: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                writes  = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign reg_write = writes && (rd != 5'd0);

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_pc_q, ex_op1_q, ex_op2_q, ex_imm_q;
    logic [31:0]     ex_instr_q;
    logic [4:0]      ex_rd_q;
    logic            ex_reg_write_q, ex_illegal_q;
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [NUM_REGS-1:0] busy;

    // A register being written back this cycle is free when it can be bypassed;
    // the instruction sitting in ID/EX blocks even while it is leaving.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            busy[i] = (i != 0) &&
                      ((pend_q[i] && !(BYPASS_EN && bus.wb_we && bus.wb_rd == 5'(i))) ||
                       (ex_valid_q && ex_reg_write_q && ex_rd_q == 5'(i)));
        end
    end

    function automatic logic [XLEN-1:0] resolve(input logic [4:0]      r,
                                                input logic [XLEN-1:0] rdata,
                                                input logic            we,
                                                input logic [4:0]      wrd,
                                                input logic [XLEN-1:0] wdata);
        if (r == 5'd0)                     return '0;
        else if (BYPASS_EN && we && wrd == r) return wdata;
        else                               return rdata;
    endfunction

    logic hazard, accept, handoff;

    assign hazard  = bus.if_valid && ((use_rs1 && busy[rs1]) || (use_rs2 && busy[rs2]) ||
                                      (reg_write && busy[rd]));
    assign bus.if_ready = !bus.flush && !hazard && (!ex_valid_q || bus.ex_ready);
    assign accept  = bus.if_valid && bus.if_ready;
    assign handoff = ex_valid_q && bus.ex_ready && !bus.flush;

    always_comb begin
        ex_valid_d = ex_valid_q;
        if (bus.flush)   ex_valid_d = 1'b0;
        else if (accept) ex_valid_d = 1'b1;
        else if (handoff) ex_valid_d = 1'b0;
    end

    // Set after clear so a handoff wins over a same-index write-back.
    always_comb begin
        pend_d = pend_q;
        if (bus.wb_we) pend_d[bus.wb_rd] = 1'b0;
        if (handoff && ex_reg_write_q) pend_d[ex_rd_q] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_pc_q        <= '0;
            ex_instr_q     <= '0;
            ex_op1_q       <= '0;
            ex_op2_q       <= '0;
            ex_imm_q       <= '0;
            ex_rd_q        <= '0;
            ex_reg_write_q <= 1'b0;
            ex_illegal_q   <= 1'b0;
            pend_q         <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            pend_q     <= pend_d;
            if (accept) begin
                ex_pc_q        <= bus.if_pc;
                ex_instr_q     <= instr;
                ex_op1_q       <= resolve(rs1, bus.rf_rdata1, bus.wb_we, bus.wb_rd, bus.wb_data);
                ex_op2_q       <= resolve(rs2, bus.rf_rdata2, bus.wb_we, bus.wb_rd, bus.wb_data);
                ex_imm_q       <= XLEN'($signed(imm));
                ex_rd_q        <= rd;
                ex_reg_write_q <= reg_write;
                ex_illegal_q   <= illegal;
            end
        end
    end

    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_pc        = ex_pc_q;
    assign bus.ex_instr     = ex_instr_q;
    assign bus.ex_op1       = ex_op1_q;
    assign bus.ex_op2       = ex_op2_q;
    assign bus.ex_imm       = ex_imm_q;
    assign bus.ex_rd        = ex_rd_q;
    assign bus.ex_reg_write = ex_reg_write_q;
    assign bus.ex_illegal   = ex_illegal_q;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed hazard/decode/flush/reset steps on a bypassing and a
// non-bypassing instance, then random traffic against an instruction-level model.
module tb_id_stage;
    localparam int unsigned XLEN = 32;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_stage_if #(.XLEN(XLEN)) bus_b ();
    id_stage_if #(.XLEN(XLEN)) bus_n ();

    id_stage #(.XLEN(XLEN), .NUM_REGS(32), .BYPASS_EN(1'b1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));
    id_stage #(.XLEN(XLEN), .NUM_REGS(32), .BYPASS_EN(1'b0)) dut_n (
        .clk(clk), .reset(reset), .bus(bus_n.slave));

    int unsigned errors = 0;
    int unsigned checks = 0;

    function automatic logic [31:0] seed(input int i);
        return (i == 0) ? 32'h0 : 32'hC0DE_0000 + 32'(i) * 32'h101;
    endfunction

    // Register files seen by each instance: combinational read, write on the edge.
    logic [31:0] rf_b [32];
    logic [31:0] rf_n [32];
    assign bus_b.rf_rdata1 = rf_b[bus_b.rf_rs1];
    assign bus_b.rf_rdata2 = rf_b[bus_b.rf_rs2];
    assign bus_n.rf_rdata1 = rf_n[bus_n.rf_rs1];
    assign bus_n.rf_rdata2 = rf_n[bus_n.rf_rs2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_b[i] <= seed(i);
                rf_n[i] <= seed(i);
            end
        end else begin
            if (bus_b.wb_we && bus_b.wb_rd != 5'd0) rf_b[bus_b.wb_rd] <= bus_b.wb_data;
            if (bus_n.wb_we && bus_n.wb_rd != 5'd0) rf_n[bus_n.wb_rd] <= bus_n.wb_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                           input logic er, input logic fl, input logic we,
                           input logic [4:0] wrd, input logic [31:0] wd);
        bus_b.if_valid = v;  bus_b.if_instr = ins; bus_b.if_pc = pc;
        bus_b.ex_ready = er; bus_b.flush = fl;
        bus_b.wb_we = we;    bus_b.wb_rd = wrd;    bus_b.wb_data = wd;
    endtask

    task automatic drive_n(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                           input logic er, input logic fl, input logic we,
                           input logic [4:0] wrd, input logic [31:0] wd);
        bus_n.if_valid = v;  bus_n.if_instr = ins; bus_n.if_pc = pc;
        bus_n.ex_ready = er; bus_n.flush = fl;
        bus_n.wb_we = we;    bus_n.wb_rd = wrd;    bus_n.wb_data = wd;
    endtask

    // Encoders: build instruction words from the field values the model expects back.
    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [31:0] imm);
        return {imm[11:0], rs1, 3'b000, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [31:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_ST};
    endfunction
    function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [31:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BR};
    endfunction
    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [31:0] imm);
        return {imm[31:12], rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction
    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, OP_REG};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic        u1, u2, wr, ill;
        logic [4:0]  rd, rs1, rs2;
    } inst_t;

    task automatic gen(output inst_t t);
        logic [31:0] r;
        logic [6:0]  op;
        logic        w;
        int unsigned k;
        r = $urandom();
        k = $urandom_range(0, 9);
        t.rd  = 5'($urandom_range(0, 5));
        t.rs1 = 5'($urandom_range(0, 5));
        t.rs2 = 5'($urandom_range(0, 5));
        t.u1 = 1'b0; t.u2 = 1'b0; t.ill = 1'b0; t.imm = '0; w = 1'b1;
        case (k)
            0, 1: begin
                t.imm   = r & 32'hFFFF_F000;
                t.instr = enc_u((k == 0) ? OP_LUI : OP_AUIPC, t.rd, t.imm);
            end
            2: begin
                t.imm   = {{11{r[20]}}, r[20:1], 1'b0};
                t.instr = enc_j(t.rd, t.imm);
            end
            3, 4, 5: begin
                op      = (k == 3) ? OP_JALR : ((k == 4) ? OP_LD : OP_IMM);
                t.imm   = {{20{r[11]}}, r[11:0]};
                t.instr = enc_i(op, t.rd, t.rs1, t.imm);
                t.u1    = 1'b1;
            end
            6: begin
                t.imm   = {{20{r[11]}}, r[11:0]};
                t.instr = enc_s(t.rs1, t.rs2, t.imm);
                t.u1 = 1'b1; t.u2 = 1'b1; w = 1'b0;
            end
            7: begin
                t.imm   = {{19{r[12]}}, r[12:1], 1'b0};
                t.instr = enc_b(t.rs1, t.rs2, t.imm);
                t.u1 = 1'b1; t.u2 = 1'b1; w = 1'b0;
            end
            8: begin
                t.instr = enc_r(t.rd, t.rs1, t.rs2);
                t.u1 = 1'b1; t.u2 = 1'b1;
            end
            default: begin
                do op = 7'($urandom());
                while (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST,
                                  OP_IMM, OP_REG});
                t.instr = {r[31:7], op};
                t.ill = 1'b1; w = 1'b0;
            end
        endcase
        t.wr = w && (t.rd != 5'd0);
    endtask

    // Model: the instruction held in ID/EX plus the set of handed-off, unretired writes.
    logic        m_v;
    inst_t       m_rec;
    logic [31:0] m_pc, m_op1, m_op2;
    logic [4:0]  outq [$];

    function automatic logic m_busy(input logic [4:0] r);
        logic found;
        found = 1'b0;
        foreach (outq[i]) if (outq[i] == r) found = 1'b1;
        return (r != 5'd0) && (found || (m_v && m_rec.wr && m_rec.rd == r));
    endfunction

    function automatic logic [31:0] m_opnd(input logic [4:0] r, input logic we,
                                           input logic [4:0] wrd, input logic [31:0] wd);
        if (r == 5'd0) return 32'h0;
        if (we && wrd == r) return wd;
        return rf_b[r];
    endfunction

    task automatic check_ex();
        chk("rand_ex_valid", bus_b.ex_valid, m_v);
        if (m_v) begin
            chk("rand_ex_pc", bus_b.ex_pc, m_pc);
            chk("rand_ex_instr", bus_b.ex_instr, m_rec.instr);
            chk("rand_ex_reg_write", bus_b.ex_reg_write, m_rec.wr);
            chk("rand_ex_illegal", bus_b.ex_illegal, m_rec.ill);
            if (!m_rec.ill) chk("rand_ex_imm", bus_b.ex_imm, m_rec.imm);
            if (m_rec.wr)   chk("rand_ex_rd", bus_b.ex_rd, m_rec.rd);
            if (m_rec.u1)   chk("rand_ex_op1", bus_b.ex_op1, m_op1);
            if (m_rec.u2)   chk("rand_ex_op2", bus_b.ex_op2, m_op2);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addi1, add211, addi6, add700, add766;
        inst_t       cur;
        logic        v, er, fl, we, haz, exp_rdy, hand;
        logic [4:0]  wrd;
        logic [31:0] wd, pc;
        int unsigned idx;

        addi1  = enc_i(OP_IMM, 5'd1, 5'd0, 32'd5);
        add211 = enc_r(5'd2, 5'd1, 5'd1);
        addi6  = enc_i(OP_IMM, 5'd6, 5'd0, 32'd1);
        add700 = enc_r(5'd7, 5'd0, 5'd0);
        add766 = enc_r(5'd7, 5'd6, 5'd6);

        reset = 1'b1;
        drive_b(0, 0, 0, 0, 0, 0, 0, 0);
        drive_n(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst_ex_valid", bus_b.ex_valid, 0);
        chk("rst_ex_pc", bus_b.ex_pc, 0);
        chk("rst_ex_instr", bus_b.ex_instr, 0);
        chk("rst_ex_imm", bus_b.ex_imm, 0);
        chk("rst_ex_reg_write", bus_b.ex_reg_write, 0);
        chk("rst_ex_illegal", bus_b.ex_illegal, 0);
        reset = 1'b0;

        // RAW on x1 with write-back bypass.
        drive_b(1, addi1, 32'h100, 1, 0, 0, 0, 0);
        @(negedge clk); chk("t2_addi_ready", bus_b.if_ready, 1);
        tick();
        chk("t2_addi_valid", bus_b.ex_valid, 1);
        chk("t2_addi_pc", bus_b.ex_pc, 32'h100);
        chk("t2_addi_imm", bus_b.ex_imm, 5);
        chk("t2_addi_rd", bus_b.ex_rd, 1);
        chk("t2_addi_rw", bus_b.ex_reg_write, 1);
        drive_b(1, add211, 32'h104, 1, 0, 0, 0, 0);
        @(negedge clk); chk("t2_stall_ex", bus_b.if_ready, 0);
        tick(); chk("t2_handoff_valid", bus_b.ex_valid, 0);
        @(negedge clk); chk("t2_stall_pend", bus_b.if_ready, 0);
        tick();
        drive_b(1, add211, 32'h104, 1, 0, 1, 5'd1, 32'd5);
        @(negedge clk); chk("t2_bypass_ready", bus_b.if_ready, 1);
        tick();
        chk("t2_add_valid", bus_b.ex_valid, 1);
        chk("t2_add_instr", bus_b.ex_instr, add211);
        chk("t2_add_op1", bus_b.ex_op1, 5);
        chk("t2_add_op2", bus_b.ex_op2, 5);

        // Immediates and illegal opcode.
        drive_b(1, enc_s(5'd4, 5'd3, 32'd8), 32'h200, 1, 0, 0, 0, 0);
        @(negedge clk); chk("t4_sw_ready", bus_b.if_ready, 1);
        tick();
        chk("t4_sw_imm", bus_b.ex_imm, 8);
        chk("t4_sw_rw", bus_b.ex_reg_write, 0);
        chk("t4_sw_op1", bus_b.ex_op1, seed(4));
        chk("t4_sw_op2", bus_b.ex_op2, seed(3));
        drive_b(1, enc_b(5'd0, 5'd0, 32'hFFFF_FFFC), 32'h204, 1, 0, 0, 0, 0);
        tick();
        chk("t4_beq_imm", bus_b.ex_imm, 32'hFFFF_FFFC);
        chk("t4_beq_rw", bus_b.ex_reg_write, 0);
        chk("t4_beq_illegal", bus_b.ex_illegal, 0);
        drive_b(1, 32'h0000_007F, 32'h208, 1, 0, 0, 0, 0);
        tick();
        chk("t4_ill_illegal", bus_b.ex_illegal, 1);
        chk("t4_ill_rw", bus_b.ex_reg_write, 0);

        // Hold for three cycles, then flush; the flushed x6 write never goes pending.
        drive_b(0, 0, 0, 1, 0, 0, 0, 0);
        tick(); chk("t5_drain_valid", bus_b.ex_valid, 0);
        drive_b(1, addi6, 32'h300, 1, 0, 0, 0, 0);
        @(negedge clk); chk("t5_addi_ready", bus_b.if_ready, 1);
        tick();
        drive_b(1, add700, 32'h304, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("t5_hold_ready", bus_b.if_ready, 0);
            tick();
            chk("t5_hold_valid", bus_b.ex_valid, 1);
            chk("t5_hold_instr", bus_b.ex_instr, addi6);
            chk("t5_hold_pc", bus_b.ex_pc, 32'h300);
            chk("t5_hold_rd", bus_b.ex_rd, 6);
        end
        drive_b(1, add700, 32'h304, 1, 1, 0, 0, 0);
        @(negedge clk); chk("t5_flush_ready", bus_b.if_ready, 0);
        tick(); chk("t5_flush_valid", bus_b.ex_valid, 0);
        drive_b(1, add766, 32'h308, 1, 0, 0, 0, 0);
        @(negedge clk); chk("t5_no_pend", bus_b.if_ready, 1);
        tick();
        chk("t5_add_valid", bus_b.ex_valid, 1);
        chk("t5_add_op1", bus_b.ex_op1, seed(6));

        // WAW on x5, then back-to-back x0 writes.
        drive_b(1, enc_i(OP_IMM, 5'd5, 5'd0, 32'd1), 32'h400, 1, 0, 0, 0, 0);
        @(negedge clk); chk("t6_first_ready", bus_b.if_ready, 1);
        tick();
        drive_b(1, enc_i(OP_IMM, 5'd5, 5'd0, 32'd2), 32'h404, 1, 0, 0, 0, 0);
        @(negedge clk); chk("t6_waw_ex", bus_b.if_ready, 0);
        tick();
        @(negedge clk); chk("t6_waw_pend", bus_b.if_ready, 0);
        tick();
        drive_b(1, enc_i(OP_IMM, 5'd5, 5'd0, 32'd2), 32'h404, 1, 0, 1, 5'd5, 32'd1);
        @(negedge clk); chk("t6_waw_wb", bus_b.if_ready, 1);
        tick();
        chk("t6_second_valid", bus_b.ex_valid, 1);
        chk("t6_second_imm", bus_b.ex_imm, 2);
        chk("t6_second_rd", bus_b.ex_rd, 5);
        drive_b(1, enc_i(OP_IMM, 5'd0, 5'd0, 32'd1), 32'h408, 1, 0, 0, 0, 0);
        @(negedge clk); chk("t6_x0_a", bus_b.if_ready, 1);
        tick();
        drive_b(1, enc_i(OP_IMM, 5'd0, 5'd0, 32'd3), 32'h40C, 1, 0, 0, 0, 0);
        @(negedge clk); chk("t6_x0_b", bus_b.if_ready, 1);
        tick();
        chk("t6_x0_rw", bus_b.ex_reg_write, 0);
        chk("t6_x0_imm", bus_b.ex_imm, 3);

        // Asynchronous reset mid-cycle with writes pending on x2, x5 and x7.
        drive_b(0, 0, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("t1_valid", bus_b.ex_valid, 0);
        chk("t1_pc", bus_b.ex_pc, 0);
        chk("t1_instr", bus_b.ex_instr, 0);
        chk("t1_imm", bus_b.ex_imm, 0);
        chk("t1_rd", bus_b.ex_rd, 0);
        chk("t1_op1", bus_b.ex_op1, 0);
        @(negedge clk); reset = 1'b0;
        tick();
        drive_b(1, enc_r(5'd3, 5'd2, 5'd5), 32'h500, 1, 0, 0, 0, 0);
        @(negedge clk); chk("t1_pend_cleared", bus_b.if_ready, 1);
        tick();
        chk("t1_after_op1", bus_b.ex_op1, seed(2));
        chk("t1_after_op2", bus_b.ex_op2, seed(5));
        drive_b(0, 0, 0, 1, 0, 0, 0, 0);

        // Without bypass the dependent issues one cycle after write-back.
        drive_n(1, addi1, 32'h600, 1, 0, 0, 0, 0);
        @(negedge clk); chk("t3_addi_ready", bus_n.if_ready, 1);
        tick();
        drive_n(1, add211, 32'h604, 1, 0, 0, 0, 0);
        @(negedge clk); chk("t3_stall_ex", bus_n.if_ready, 0);
        tick();
        @(negedge clk); chk("t3_stall_pend", bus_n.if_ready, 0);
        tick();
        drive_n(1, add211, 32'h604, 1, 0, 1, 5'd1, 32'd5);
        @(negedge clk); chk("t3_wb_stall", bus_n.if_ready, 0);
        tick(); chk("t3_wb_valid", bus_n.ex_valid, 0);
        drive_n(1, add211, 32'h604, 1, 0, 0, 0, 0);
        @(negedge clk); chk("t3_after_wb_ready", bus_n.if_ready, 1);
        tick();
        chk("t3_add_valid", bus_n.ex_valid, 1);
        chk("t3_add_op1", bus_n.ex_op1, 5);
        chk("t3_add_op2", bus_n.ex_op2, 5);
        drive_n(0, 0, 0, 1, 0, 0, 0, 0);

        // Random traffic.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_v = 1'b0;
        outq.delete();
        for (int cyc = 0; cyc < 500; cyc++) begin
            gen(cur);
            v  = ($urandom_range(0, 3) != 0);
            er = ($urandom_range(0, 9) < 7);
            fl = ($urandom_range(0, 19) == 0);
            pc = $urandom();
            wd = $urandom();
            we = 1'b0;
            wrd = 5'd0;
            if (outq.size() > 0 && $urandom_range(0, 2) == 0) begin
                idx = $urandom_range(0, outq.size() - 1);
                wrd = outq[idx];
                outq.delete(idx);
                we  = 1'b1;
            end
            drive_b(v, cur.instr, pc, er, fl, we, wrd, wd);
            @(negedge clk);
            haz = v && ((cur.u1 && m_busy(cur.rs1)) || (cur.u2 && m_busy(cur.rs2)) ||
                        (cur.wr && m_busy(cur.rd)));
            exp_rdy = !fl && !haz && (!m_v || er);
            chk("rand_if_ready", bus_b.if_ready, exp_rdy);
            chk("rand_rf_rs1", bus_b.rf_rs1, cur.instr[19:15]);
            chk("rand_rf_rs2", bus_b.rf_rs2, cur.instr[24:20]);
            hand = m_v && er && !fl;
            if (hand && m_rec.wr) outq.push_back(m_rec.rd);
            if (fl) begin
                m_v = 1'b0;
            end else if (v && exp_rdy) begin
                m_v   = 1'b1;
                m_rec = cur;
                m_pc  = pc;
                m_op1 = m_opnd(cur.rs1, we, wrd, wd);
                m_op2 = m_opnd(cur.rs2, we, wrd, wd);
            end else if (hand) begin
                m_v = 1'b0;
            end
            tick();
            check_ex();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
